// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and baud
// timing helpers used by both the transmitter and receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Whole clock cycles per bit; callers must keep the result >= 4.
    function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                               input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                                input int unsigned baud);
        return bit_cycles(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, deframed byte and status out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_pin;
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_pin,
        output data_out,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_pin,
        input  data_out,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so no false start bit is seen when reset releases.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit using an internal baud counter,
// emits a one-cycle rx_valid per good frame or frame_err per bad stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);

    localparam int unsigned BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned HALF_CYCLES = half_cycles(CLK_HZ, BAUD);
    localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYCLES - 1);
    localparam logic [2:0]       BIDX_LAST    = 3'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bidx;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;

    logic w_rx_s;
    logic w_bit_end;
    logic w_half_end;
    logic w_cnt_inc;
    logic w_shift;
    logic w_valid_set;
    logic w_ferr_set;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx_pin),
        .o_sync  (w_rx_s)
    );

    assign w_bit_end  = (r_cnt == CNT_BIT_END);
    assign w_half_end = (r_cnt == CNT_HALF_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_rx_s) w_next = START;
            START:   if (w_half_end) w_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_bit_end && (r_bidx == BIDX_LAST)) w_next = STOP;
            STOP:    if (w_bit_end) w_next = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The counter clears whenever it is not told to advance, which covers
    // IDLE, BREAK and every half/full-bit terminal count in one rule.
    always_comb begin
        w_cnt_inc   = 1'b0;
        w_shift     = 1'b0;
        w_valid_set = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            START: w_cnt_inc = !w_half_end;
            DATA: begin
                w_cnt_inc = !w_bit_end;
                w_shift   = w_bit_end;
            end
            STOP: begin
                w_cnt_inc   = !w_bit_end;
                w_valid_set = w_bit_end && w_rx_s;
                w_ferr_set  = w_bit_end && !w_rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bidx  <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_inc ? r_cnt + CNT_W'(1) : '0;
            r_valid <= w_valid_set;
            r_ferr  <= w_ferr_set;
            if (w_shift) begin
                r_sh   <= {w_rx_s, r_sh[DATA_BITS-1:1]};
                r_bidx <= r_bidx + 3'd1;
            end else if (r_state != DATA) begin
                r_bidx <= '0;
            end
            if (w_valid_set) begin
                r_data <= r_sh;
            end
        end
    end

    assign bus.data_out  = r_data;
    assign bus.rx_valid  = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a scoreboard queue holds
// bytes expected on rx_valid, popped and compared by a negedge monitor.
module tb_uart_rx;

    localparam int unsigned CLK_P = 100;
    localparam int unsigned BIT_T = 16 * CLK_P;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int unsigned last_valid_cyc = 0;
    logic [7:0] exp_q[$];

    uart_rx_if bus ();

    uart_rx #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(CLK_P / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid || bus.frame_err) begin
                n_cmp++;
                assert (!(bus.rx_valid && bus.frame_err)) else begin
                    n_err++;
                    $error("FAIL valid_ferr_exclusive: observed both high expected at most one");
                end
            end
            if (bus.frame_err) n_ferr++;
            if (bus.rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_err++;
                    $error("FAIL unexpected_rx_valid: observed data 0x%0h expected no frame", bus.data_out);
                end
                if (exp_q.size() > 0) chk("scoreboard_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tx_frame(input logic [7:0] d, input logic stop, input int unsigned bt);
        bus.rx_pin = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            bus.rx_pin = d[i];
            #(bt);
        end
        bus.rx_pin = stop;
        #(bt);
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int f0;
        int unsigned t0;
        int unsigned lat;

        bus.rx_pin = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_data_out", 32'(bus.data_out), 32'h00);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single frame 0x55 with latency measurement
        #1;
        v0 = n_valid; f0 = n_ferr; t0 = cyc;
        exp_q.push_back(8'h55);
        tx_frame(8'h55, 1'b1, BIT_T);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("f55_valid_count", 32'(n_valid - v0), 32'd1);
        chk("f55_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("f55_data_out", 32'(bus.data_out), 32'h55);
        chk("f55_busy_idle", 32'(bus.busy), 32'h0);
        lat = last_valid_cyc - t0;
        n_cmp++;
        assert (lat >= 154 && lat <= 156) else begin
            n_err++;
            $error("FAIL f55_latency: observed %0d expected 155 +/-1", lat);
        end

        // Short low glitch in idle
        @(posedge clk); #1;
        v0 = n_valid; f0 = n_ferr;
        bus.rx_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.rx_pin = 1'b1;
        @(negedge clk);
        chk("glitch_busy_start", 32'(bus.busy), 32'h1);
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_back_idle", 32'(bus.busy), 32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_no_valid", 32'(n_valid - v0), 32'd0);
        chk("glitch_no_ferr", 32'(n_ferr - f0), 32'd0);

        // Bad stop bit followed by a held-low line
        @(posedge clk); #1;
        v0 = n_valid; f0 = n_ferr;
        tx_frame(8'h3C, 1'b0, BIT_T);
        repeat (23) @(posedge clk);
        @(negedge clk);
        chk("break_busy_held", 32'(bus.busy), 32'h1);
        @(posedge clk); #1 bus.rx_pin = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("break_ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("break_no_valid", 32'(n_valid - v0), 32'd0);
        chk("break_data_kept", 32'(bus.data_out), 32'h55);
        chk("break_busy_released", 32'(bus.busy), 32'h0);

        // Back-to-back frames with no idle gap
        @(posedge clk); #1;
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        tx_frame(8'hA5, 1'b1, BIT_T);
        tx_frame(8'h00, 1'b1, BIT_T);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
        chk("b2b_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("b2b_data_out", 32'(bus.data_out), 32'h00);

        // Reset during data bit 4 of 0xFF, then a clean 0x81
        @(posedge clk); #1;
        v0 = n_valid; f0 = n_ferr;
        bus.rx_pin = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            bus.rx_pin = 1'b1;
            #(BIT_T);
        end
        #(BIT_T / 2);
        @(negedge clk);
        chk("rst_busy_mid_frame", 32'(bus.busy), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_data_out_cleared", 32'(bus.data_out), 32'h00);
        chk("rst_busy_cleared", 32'(bus.busy), 32'h0);
        chk("rst_rx_valid_low", 32'(bus.rx_valid), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("rst_partial_discarded", 32'(n_valid - v0), 32'd0);
        chk("rst_partial_no_ferr", 32'(n_ferr - f0), 32'd0);
        @(posedge clk); #1;
        v0 = n_valid;
        exp_q.push_back(8'h81);
        tx_frame(8'h81, 1'b1, BIT_T);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("post_rst_valid_count", 32'(n_valid - v0), 32'd1);
        chk("post_rst_data_out", 32'(bus.data_out), 32'h81);

        // Baud skew: 3% slow then 3% fast
        @(posedge clk); #1;
        v0 = n_valid; f0 = n_ferr;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01);
        tx_frame(8'hFF, 1'b1, (BIT_T * 103) / 100);
        repeat (5) @(posedge clk);
        #1;
        tx_frame(8'h01, 1'b1, (BIT_T * 97) / 100);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("skew_valid_count", 32'(n_valid - v0), 32'd2);
        chk("skew_no_ferr", 32'(n_ferr - f0), 32'd0);
        chk("skew_data_out", 32'(bus.data_out), 32'h01);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
